// File: rtl/fibonacci_decode.sv
// Serial Fibonacci-code to binary decoder: walks the set bits of the code word,
// fetches each bit's weight from a synchronous ROM and accumulates the sum.
module fibonacci_decode #(
   parameter int unsigned FIB_W   = 32,
   parameter int unsigned BIN_W   = 16,
   parameter int unsigned MAX_BIT = 22,
   parameter int unsigned ADDR_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              begin_f_b,
   input  logic [FIB_W-1:0]  input_fib,
   input  logic [BIN_W-1:0]  mema,
   output logic [ADDR_W-1:0] cnt_a,
   output logic [BIN_W-1:0]  binary_out,
   output logic              convert_done,
   output logic              overflow,
   output logic              range_err,
   output logic              non_canonical
);

   localparam int unsigned IDX_W = $clog2(FIB_W + 1);
   localparam int unsigned ACC_W = BIN_W + 1;
   localparam logic [FIB_W-1:0] KEEP_MASK = {FIB_W{1'b1}} >> (FIB_W - MAX_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SCAN = 3'd1,
      S_WAIT = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [FIB_W-1:0]   sr_q, sr_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]  cnt_a_q, cnt_a_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               rng_q, rng_d;
   logic               nc_q, nc_d;
   logic [ACC_W:0]     sum_c;

   // One extra bit above the accumulator catches a carry out of the sticky MSB.
   assign sum_c = {1'b0, acc_q} + (ACC_W + 1)'(mema);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      cnt_a_d = cnt_a_q;
      bin_d   = bin_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      rng_d   = rng_q;
      nc_d    = nc_q;
      case (state_q)
         S_IDLE: begin
            if (begin_f_b) begin
               sr_d    = input_fib & KEEP_MASK;
               acc_d   = '0;
               idx_d   = '0;
               rng_d   = |(input_fib & ~KEEP_MASK);
               nc_d    = |(input_fib & (input_fib >> 1));
               ovf_d   = 1'b0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (sr_q == '0) begin
               state_d = S_DONE;
            end else if (!sr_q[0]) begin
               sr_d  = sr_q >> 1;
               idx_d = idx_q + IDX_W'(1);
            end else begin
               cnt_a_d = ADDR_W'(idx_q);
               state_d = S_WAIT;
            end
         end
         S_WAIT: state_d = S_ACC;
         S_ACC: begin
            acc_d   = sum_c[ACC_W-1:0];
            ovf_d   = ovf_q | sum_c[ACC_W] | sum_c[ACC_W-1] | acc_q[ACC_W-1];
            sr_d    = sr_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SCAN;
         end
         S_DONE: begin
            bin_d   = acc_q[BIN_W-1:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         cnt_a_q <= '0;
         bin_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rng_q   <= 1'b0;
         nc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         cnt_a_q <= cnt_a_d;
         bin_q   <= bin_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         rng_q   <= rng_d;
         nc_q    <= nc_d;
      end
   end

   assign cnt_a         = cnt_a_q;
   assign binary_out    = bin_q;
   assign convert_done  = done_q;
   assign overflow      = ovf_q;
   assign range_err     = rng_q;
   assign non_canonical = nc_q;

endmodule

// File: tb/tb_fibonacci_decode.sv
// Directed bench for fibonacci_decode with a synchronous Fibonacci weight ROM model.
module tb_fibonacci_decode;

   localparam int unsigned FIB_W  = 32;
   localparam int unsigned BIN_W  = 16;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              begin_f_b = 1'b0;
   logic [FIB_W-1:0]  input_fib = '0;
   logic [BIN_W-1:0]  mema = '0;
   logic [ADDR_W-1:0] cnt_a;
   logic [BIN_W-1:0]  binary_out;
   logic              convert_done;
   logic              overflow;
   logic              range_err;
   logic              non_canonical;

   logic [BIN_W-1:0]  rom [1024];
   int n_checks = 0;
   int n_pass   = 0;
   int lat;
   int addr_q[$];

   fibonacci_decode dut (
      .clk          (clk),
      .rst          (rst),
      .begin_f_b    (begin_f_b),
      .input_fib    (input_fib),
      .mema         (mema),
      .cnt_a        (cnt_a),
      .binary_out   (binary_out),
      .convert_done (convert_done),
      .overflow     (overflow),
      .range_err    (range_err),
      .non_canonical(non_canonical)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mema <= rom[cnt_a];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Starts a conversion and counts edges until convert_done; records cnt_a changes.
   task automatic run(input logic [FIB_W-1:0] code, input bit mid_pulse);
      logic [ADDR_W-1:0] prev;
      addr_q.delete();
      prev = cnt_a;
      @(negedge clk);
      input_fib = code;
      begin_f_b = 1'b1;
      @(posedge clk);
      #1;
      begin_f_b = 1'b0;
      lat = 999;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         begin_f_b = 1'b0;
         if (cnt_a != prev) begin
            addr_q.push_back(int'(cnt_a));
            prev = cnt_a;
         end
         if (mid_pulse && n == 3) begin
            input_fib = 32'h0000_0003;
            begin_f_b = 1'b1;
         end
         if (convert_done) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int a, b, t, spurious;
      a = 1;
      b = 2;
      for (int i = 0; i < 1024; i++) begin
         rom[i] = BIN_W'(a);
         t = a + b;
         a = b;
         b = t;
      end

      #1;
      chk("rst_binary_out", 32'(binary_out), 0);
      chk("rst_done", 32'(convert_done), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_range_err", 32'(range_err), 0);
      chk("rst_non_canonical", 32'(non_canonical), 0);
      chk("rst_cnt_a", 32'(cnt_a), 0);
      #12 rst = 1'b1;

      run(32'h0, 1'b0);
      chk("zero_latency", 32'(lat), 2);
      chk("zero_value", 32'(binary_out), 0);
      chk("zero_flags", {29'd0, overflow, range_err, non_canonical}, 0);
      @(posedge clk);
      #1;
      chk("zero_done_pulse_width", 32'(convert_done), 0);

      run(32'h0000_000A, 1'b0);
      chk("x0a_latency", 32'(lat), 10);
      chk("x0a_value", 32'(binary_out), 7);
      chk("x0a_non_canonical", 32'(non_canonical), 0);
      chk("x0a_addr_count", 32'(addr_q.size()), 2);
      if (addr_q.size() == 2) begin
         chk("x0a_addr0", 32'(addr_q[0]), 1);
         chk("x0a_addr1", 32'(addr_q[1]), 3);
      end

      // Back-to-back: start strobe lands in the convert_done cycle.
      run(32'h0000_0003, 1'b0);
      chk("x03_latency", 32'(lat), 8);
      chk("x03_value", 32'(binary_out), 3);
      chk("x03_non_canonical", 32'(non_canonical), 1);

      run(32'h0000_4020, 1'b0);
      chk("rt1000_latency", 32'(lat), 21);
      chk("rt1000_value", 32'(binary_out), 1000);
      chk("rt1000_non_canonical", 32'(non_canonical), 0);

      run(32'h0060_0000, 1'b0);
      chk("b21_22_latency", 32'(lat), 29);
      chk("b21_22_value", 32'(binary_out), 9489);
      chk("b21_22_overflow", 32'(overflow), 1);
      chk("b21_22_non_canonical", 32'(non_canonical), 1);
      chk("b21_22_range_err", 32'(range_err), 0);

      run(32'h8000_0001, 1'b0);
      chk("b31_latency", 32'(lat), 5);
      chk("b31_value", 32'(binary_out), 1);
      chk("b31_range_err", 32'(range_err), 1);
      chk("b31_overflow", 32'(overflow), 0);
      chk("b31_non_canonical", 32'(non_canonical), 0);

      run(32'h0000_000A, 1'b1);
      chk("mid_latency", 32'(lat), 10);
      chk("mid_value", 32'(binary_out), 7);
      spurious = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (convert_done) spurious++;
      end
      chk("mid_no_second_done", 32'(spurious), 0);

      // Reset in the middle of a scan aborts it with no pulse.
      @(negedge clk);
      input_fib = 32'h0000_4020;
      begin_f_b = 1'b1;
      @(posedge clk);
      #1;
      begin_f_b = 1'b0;
      spurious = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (convert_done) spurious++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_binary_out", 32'(binary_out), 0);
      chk("abort_flags", {29'd0, overflow, range_err, non_canonical}, 0);
      chk("abort_cnt_a", 32'(cnt_a), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (convert_done) spurious++;
      end
      chk("abort_no_done", 32'(spurious), 0);
      @(negedge clk);
      rst = 1'b1;
      run(32'h0000_000A, 1'b0);
      chk("post_abort_latency", 32'(lat), 10);
      chk("post_abort_value", 32'(binary_out), 7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
